// File: rtl/gol_sequencer_if.sv
// rtl/gol_sequencer_if.sv - launch/busy handshake between the run-control sequencer and its two workers
//
// Purpose: bundles the go/busy handshakes of the next-field iterator (nfi) and
// the field config loader (fcl), plus the load qualifiers.
// Signals:
//   nfi_go       sequencer -> iterator  one-cycle generation launch
//   nfi_busy     iterator -> sequencer  iterator is simulating
//   fcl_go       sequencer -> loader    one-cycle load launch
//   fcl_busy     loader -> sequencer    loader is loading
//   fcl_cfg_sel  sequencer -> loader    config index, stable from go until load done
//   fcl_clear    sequencer -> loader    write all-dead field, stable from go until load done
// Modports: master = sequencer side, slave = worker side.

interface gol_sequencer_if #(
  parameter int CFG_W = 1
) ();
  logic             nfi_go;
  logic             nfi_busy;
  logic             fcl_go;
  logic             fcl_busy;
  logic [CFG_W-1:0] fcl_cfg_sel;
  logic             fcl_clear;

  modport master (
    output nfi_go, fcl_go, fcl_cfg_sel, fcl_clear,
    input  nfi_busy, fcl_busy
  );

  modport slave (
    input  nfi_go, fcl_go, fcl_cfg_sel, fcl_clear,
    output nfi_busy, fcl_busy
  );
endinterface

// File: rtl/gol_sequencer.sv
// rtl/gol_sequencer.sv - Game of Life run-control sequencer (generations, config loads, ping-pong field select)
//
// Purpose: arbitrates between generation runs and config loads, owns the
// ping-pong read-field select, pause/step/speed control and a generation counter.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_cmd_toggle_pause      pulse: toggle pause
//   i_cmd_step              pulse: single generation while paused
//   i_cmd_speed_next        pulse: advance speed index (wraps)
//   i_cmd_clear             pulse: request an all-dead load
//   i_cmd_load_cfg          pulses: request load of config i (lowest index wins)
//   wk                      worker handshake interface (master side)
//   o_read_field            field being read/displayed/loaded (0 = A, 1 = B)
//   o_paused                pause flag
//   o_speed_idx             current speed index
//   o_gen_count             generations completed since the last load

module gol_sequencer #(
  parameter int NUM_CFGS      = 2,
  parameter int NUM_SPEEDS    = 4,
  parameter int BASE_PERIOD   = 3072000,
  parameter int GEN_W         = 16,
  parameter int LOAD_ON_RESET = 1,
  localparam int CFG_W = (NUM_CFGS > 1) ? $clog2(NUM_CFGS) : 1,
  localparam int SPD_W = $clog2(NUM_SPEEDS) + ((NUM_SPEEDS == 1) ? 1 : 0),
  localparam int PER_W = $clog2(BASE_PERIOD + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cmd_toggle_pause,
  input  logic                i_cmd_step,
  input  logic                i_cmd_speed_next,
  input  logic                i_cmd_clear,
  input  logic [NUM_CFGS-1:0] i_cmd_load_cfg,
  gol_sequencer_if.master     wk,
  output logic                o_read_field,
  output logic                o_paused,
  output logic [SPD_W-1:0]    o_speed_idx,
  output logic [GEN_W-1:0]    o_gen_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_GO,
    S_LOAD_ARM,
    S_LOAD_WAIT,
    S_SIM_GO,
    S_SIM_ARM,
    S_SIM_WAIT
  } state_t;

  state_t state, state_nx;

  logic             load_pend;
  logic [CFG_W-1:0] load_cfg;
  logic             load_clr;
  logic             step_pend;
  logic             tick_pend;
  logic [PER_W-1:0] timer;
  logic [CFG_W-1:0] cfg_sel_q;
  logic             clear_q;

  logic             req_new;
  logic [CFG_W-1:0] req_cfg;
  logic             eff_valid;
  logic [CFG_W-1:0] eff_cfg;
  logic             eff_clr;
  logic             sim_active;
  logic             step_req;
  logic             step_eff;
  logic [PER_W-1:0] period;
  logic             tick_eff;
  logic             launch_load;
  logic             launch_sim;
  logic             timer_clr;

  // Incoming load request; a fresh request overrides the pending one so
  // the IDLE decision can launch it with one cycle of latency.
  always_comb begin
    req_new = i_cmd_clear | (|i_cmd_load_cfg);
    req_cfg = '0;
    for (int i = NUM_CFGS - 1; i >= 0; i--) begin
      if (i_cmd_load_cfg[i]) req_cfg = CFG_W'(i);
    end
    eff_valid = req_new | load_pend;
    eff_cfg   = req_new ? req_cfg : load_cfg;
    eff_clr   = req_new ? i_cmd_clear : load_clr;
  end

  // Steps are refused while a generation is in flight so a step issued
  // during a run does not queue a second generation.
  assign sim_active = (state == S_SIM_GO) || (state == S_SIM_ARM) || (state == S_SIM_WAIT);
  assign step_req   = i_cmd_step & o_paused & ~step_pend & ~sim_active;
  assign step_eff   = step_pend | step_req;

  always_comb begin
    period = PER_W'(BASE_PERIOD) >> o_speed_idx;
    if (period == '0) period = PER_W'(1);
  end

  // The reach condition is seen combinationally so a launch can happen in
  // the same cycle the timer hits period-1, giving an exact period interval.
  assign tick_eff = tick_pend | (~o_paused & (timer == period - PER_W'(1)));

  always_comb begin
    state_nx  = state;
    wk.fcl_go = 1'b0;
    wk.nfi_go = 1'b0;
    case (state)
      S_IDLE: begin
        if (eff_valid)                state_nx = S_LOAD_GO;
        else if (tick_eff || step_eff) state_nx = S_SIM_GO;
      end
      S_LOAD_GO: begin
        wk.fcl_go = 1'b1;
        state_nx  = S_LOAD_ARM;
      end
      S_LOAD_ARM:  if (wk.fcl_busy)  state_nx = S_LOAD_WAIT;
      S_LOAD_WAIT: if (!wk.fcl_busy) state_nx = S_IDLE;
      S_SIM_GO: begin
        wk.nfi_go = 1'b1;
        state_nx  = S_SIM_ARM;
      end
      S_SIM_ARM:   if (wk.nfi_busy)  state_nx = S_SIM_WAIT;
      S_SIM_WAIT:  if (!wk.nfi_busy) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  assign launch_load = (state == S_IDLE) && (state_nx == S_LOAD_GO);
  assign launch_sim  = (state == S_IDLE) && (state_nx == S_SIM_GO);
  assign timer_clr   = launch_sim | i_cmd_speed_next | (i_cmd_toggle_pause & ~o_paused);

  assign wk.fcl_cfg_sel = cfg_sel_q;
  assign wk.fcl_clear   = clear_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pend <= (LOAD_ON_RESET != 0);
      load_cfg  <= '0;
      load_clr  <= 1'b0;
      cfg_sel_q <= '0;
      clear_q   <= 1'b0;
    end else begin
      if (launch_load) begin
        load_pend <= 1'b0;
        cfg_sel_q <= eff_cfg;
        clear_q   <= eff_clr;
      end else if (req_new) begin
        load_pend <= 1'b1;
        load_cfg  <= req_cfg;
        load_clr  <= i_cmd_clear;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pend   <= 1'b0;
      o_paused    <= 1'b1;
      o_speed_idx <= '0;
    end else begin
      if (launch_sim)    step_pend <= 1'b0;
      else if (step_req) step_pend <= 1'b1;
      if (i_cmd_toggle_pause) o_paused <= ~o_paused;
      if (i_cmd_speed_next) begin
        if (o_speed_idx == SPD_W'(NUM_SPEEDS - 1)) o_speed_idx <= '0;
        else                                       o_speed_idx <= o_speed_idx + SPD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      tick_pend <= 1'b0;
    end else if (timer_clr) begin
      timer     <= '0;
      tick_pend <= 1'b0;
    end else if (!o_paused && !tick_pend) begin
      if (timer == period - PER_W'(1)) tick_pend <= 1'b1;
      else                             timer     <= timer + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_read_field <= 1'b0;
      o_gen_count  <= '0;
    end else begin
      if (state == S_SIM_WAIT && !wk.nfi_busy) begin
        o_read_field <= ~o_read_field;
        o_gen_count  <= o_gen_count + GEN_W'(1);
      end else if (state == S_LOAD_WAIT && !wk.fcl_busy) begin
        o_gen_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gol_sequencer.sv
// tb/tb_gol_sequencer.sv - directed self-checking bench for gol_sequencer

module tb_gol_sequencer;
  logic       clk;
  logic       rst_n;
  logic       cmd_pause, cmd_step, cmd_speed, cmd_clear;
  logic [1:0] cmd_load;
  logic       read_field, paused;
  logic [1:0] speed_idx;
  logic [15:0] gen_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [3:0] nfi_cnt, fcl_cnt;
  int         model_gens;
  logic       model_rf;

  gol_sequencer_if #(.CFG_W(1)) bus ();

  gol_sequencer #(
    .NUM_CFGS(2), .NUM_SPEEDS(4), .BASE_PERIOD(16), .GEN_W(16), .LOAD_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_cmd_toggle_pause(cmd_pause),
    .i_cmd_step(cmd_step),
    .i_cmd_speed_next(cmd_speed),
    .i_cmd_clear(cmd_clear),
    .i_cmd_load_cfg(cmd_load),
    .wk(bus),
    .o_read_field(read_field),
    .o_paused(paused),
    .o_speed_idx(speed_idx),
    .o_gen_count(gen_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Worker models: busy for 5 cycles starting the cycle after go.
  assign bus.nfi_busy = (nfi_cnt != 0);
  assign bus.fcl_busy = (fcl_cnt != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nfi_cnt <= 0; fcl_cnt <= 0; model_gens <= 0; model_rf <= 0;
    end else begin
      if (bus.nfi_go) nfi_cnt <= 5;
      else if (nfi_cnt != 0) begin
        nfi_cnt <= nfi_cnt - 1;
        if (nfi_cnt == 1) begin model_gens <= model_gens + 1; model_rf <= ~model_rf; end
      end
      if (bus.fcl_go) fcl_cnt <= 5;
      else if (fcl_cnt != 0) begin
        fcl_cnt <= fcl_cnt - 1;
        if (fcl_cnt == 1) model_gens <= 0;
      end
    end
  end

  task automatic wait_nfi(input int lim, output bit seen);
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.nfi_go) begin seen = 1; break; end
    end
  endtask

  task automatic wait_fcl(input int lim, output bit seen);
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.fcl_go) begin seen = 1; break; end
    end
  endtask

  task automatic pulse_pause();
    @(negedge clk); cmd_pause = 1; @(negedge clk); cmd_pause = 0;
  endtask

  task automatic pulse_speed();
    @(negedge clk); cmd_speed = 1; @(negedge clk); cmd_speed = 0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL reset_paused got=%b exp=1", paused); end
    total++; if (gen_count !== 16'd0) begin bad++; $display("FAIL reset_gen got=%0d exp=0", gen_count); end
    total++; if (read_field !== 1'b0 || speed_idx !== 2'd0) begin bad++; $display("FAIL reset_rf_speed got=%b/%0d exp=0/0", read_field, speed_idx); end
    total++; if (bus.nfi_go !== 1'b0 || bus.fcl_go !== 1'b0) begin bad++; $display("FAIL reset_go got=%b%b exp=00", bus.nfi_go, bus.fcl_go); end
    rst_n = 1;
    @(negedge clk);
    total++; if (bus.fcl_go !== 1'b1 || bus.fcl_cfg_sel !== 1'b0 || bus.fcl_clear !== 1'b0) begin
      bad++; $display("FAIL reset_autoload got go=%b sel=%b clr=%b exp=1/0/0", bus.fcl_go, bus.fcl_cfg_sel, bus.fcl_clear);
    end
    repeat (10) @(negedge clk);
    total++; if (gen_count !== 16'd0 || read_field !== 1'b0 || paused !== 1'b1) begin
      bad++; $display("FAIL after_load got gen=%0d rf=%b p=%b exp=0/0/1", gen_count, read_field, paused);
    end
    n = 0;
    repeat (100) begin @(negedge clk); if (bus.nfi_go) n++; end
    total++; if (n != 0) begin bad++; $display("FAIL paused_no_go got=%0d exp=0", n); end
  endtask

  task automatic test_run();
    bit seen;
    int tprev;
    pulse_pause();
    wait_nfi(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL run_first_go timeout got=0 exp=1"); end
    tprev = cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_nfi(40, seen);
      total++; if (!seen || cyc - tprev != 16) begin bad++; $display("FAIL run_interval k=%0d got=%0d exp=16", k, cyc - tprev); end
      total++; if (gen_count !== 16'(k) || read_field !== k[0]) begin
        bad++; $display("FAIL run_gen k=%0d got gen=%0d rf=%b exp=%0d/%b", k, gen_count, read_field, k, k[0]);
      end
      tprev = cyc;
    end
    pulse_speed();
    pulse_speed();
    total++; if (speed_idx !== 2'd2) begin bad++; $display("FAIL speed_idx got=%0d exp=2", speed_idx); end
    wait_nfi(40, seen);
    tprev = cyc;
    for (int k = 0; k < 2; k++) begin
      wait_nfi(40, seen);
      total++; if (!seen || cyc - tprev != 8) begin bad++; $display("FAIL clamp_interval got=%0d exp=8", cyc - tprev); end
      tprev = cyc;
    end
    total++; if (gen_count !== 16'(model_gens)) begin bad++; $display("FAIL clamp_gen got=%0d exp=%0d", gen_count, model_gens); end
    pulse_pause();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_step();
    bit seen;
    int g0, n, tprev;
    g0 = model_gens;
    @(negedge clk); cmd_step = 1; @(negedge clk); cmd_step = 0;
    total++; if (bus.nfi_go !== 1'b1) begin bad++; $display("FAIL step_go got=%b exp=1", bus.nfi_go); end
    repeat (2) @(negedge clk);
    cmd_step = 1; @(negedge clk); cmd_step = 0;
    n = 0;
    repeat (30) begin @(negedge clk); if (bus.nfi_go) n++; end
    total++; if (n != 0) begin bad++; $display("FAIL step_in_wait got=%0d exp=0", n); end
    total++; if (gen_count !== 16'(g0 + 1)) begin bad++; $display("FAIL step_gen got=%0d exp=%0d", gen_count, g0 + 1); end
    pulse_speed();
    pulse_speed();
    total++; if (speed_idx !== 2'd0) begin bad++; $display("FAIL speed_wrap got=%0d exp=0", speed_idx); end
    pulse_pause();
    wait_nfi(40, seen);
    tprev = cyc;
    repeat (10) @(negedge clk);
    cmd_step = 1; @(negedge clk); cmd_step = 0;
    wait_nfi(40, seen);
    total++; if (!seen || cyc - tprev != 16) begin bad++; $display("FAIL step_running got=%0d exp=16", cyc - tprev); end
    pulse_pause();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_load_defer();
    bit seen;
    int tn;
    @(negedge clk); cmd_step = 1; @(negedge clk); cmd_step = 0;
    tn = cyc;
    @(negedge clk);
    cmd_load = 2'b10; @(negedge clk); cmd_load = 2'b00;
    wait_fcl(30, seen);
    total++; if (!seen || cyc - tn != 8) begin bad++; $display("FAIL defer_latency got=%0d exp=8", cyc - tn); end
    total++; if (bus.fcl_cfg_sel !== 1'b1 || bus.fcl_clear !== 1'b0) begin
      bad++; $display("FAIL defer_sel got sel=%b clr=%b exp=1/0", bus.fcl_cfg_sel, bus.fcl_clear);
    end
    repeat (12) @(negedge clk);
    total++; if (gen_count !== 16'd0) begin bad++; $display("FAIL defer_gen got=%0d exp=0", gen_count); end
  endtask

  task automatic test_load_select();
    @(negedge clk); cmd_load = 2'b11; @(negedge clk); cmd_load = 2'b00;
    total++; if (bus.fcl_go !== 1'b1 || bus.fcl_cfg_sel !== 1'b0 || bus.fcl_clear !== 1'b0) begin
      bad++; $display("FAIL lowest_wins got go=%b sel=%b clr=%b exp=1/0/0", bus.fcl_go, bus.fcl_cfg_sel, bus.fcl_clear);
    end
    repeat (12) @(negedge clk);
    @(negedge clk); cmd_clear = 1; cmd_load = 2'b01; @(negedge clk); cmd_clear = 0; cmd_load = 2'b00;
    total++; if (bus.fcl_go !== 1'b1 || bus.fcl_clear !== 1'b1) begin
      bad++; $display("FAIL clear_wins got go=%b clr=%b exp=1/1", bus.fcl_go, bus.fcl_clear);
    end
    repeat (3) @(negedge clk);
    total++; if (bus.fcl_clear !== 1'b1) begin bad++; $display("FAIL clear_stable got=%b exp=1", bus.fcl_clear); end
    repeat (12) @(negedge clk);
    total++; if (read_field !== model_rf) begin bad++; $display("FAIL load_rf got=%b exp=%b", read_field, model_rf); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    pulse_speed();
    pulse_pause();
    wait_nfi(40, seen);
    wait_nfi(40, seen);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    total++; if (paused !== 1'b1 || gen_count !== 16'd0 || read_field !== 1'b0 || speed_idx !== 2'd0 || bus.nfi_go !== 1'b0) begin
      bad++; $display("FAIL async_reset got p=%b gen=%0d rf=%b spd=%0d go=%b exp=1/0/0/0/0", paused, gen_count, read_field, speed_idx, bus.nfi_go);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++; if (bus.fcl_go !== 1'b1) begin bad++; $display("FAIL reset_reload got=%b exp=1", bus.fcl_go); end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    cmd_pause = 0; cmd_step = 0; cmd_speed = 0; cmd_clear = 0; cmd_load = 2'b00;
    test_reset();
    test_run();
    test_step();
    test_load_defer();
    test_load_select();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
